aes_decrypt: RTL and testbench

AES_DECRYPT -- requirements
Module: aes_decrypt

---
 rtl/aes_decrypt.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_aes_decrypt.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt.sv
// ---------------------------------------------------------------------------
// aes_decrypt -- iterative AES-128 inverse cipher, one round per clock.
//
// Bytes are in FIPS-197 order: byte 0 of a block or key sits in bits
// [127:120], and the state is column-major (byte i = row i%4, column i/4).
//
// Flow: IDLE -> KEYEXP (10 forward key steps, ending on rk10)
//            -> ROUND  (rounds 9..0; the key is walked backwards by inverse
//                       expansion, so no round-key table is stored)
//            -> DONE   (plaintext and a one-cycle valid pulse are registered)
//            -> IDLE
// A start is accepted only in IDLE. Requests that arrive while busy are
// dropped, not queued.
//
// Optional feature (macro AES_DECRYPT_KEYCACHE_EN): keep the last rk10 and
// the secret it was expanded from. A start whose secret matches skips KEYEXP,
// which cuts latency from 21 to 11 cycles.
//
// Ports:
//   clock       sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   ciphertext  128-bit block to decrypt (sampled with we in IDLE)
//   secret      128-bit cipher key (sampled with we in IDLE)
//   we          start request
//   plaintext   decrypted block, held until the next completion or reset
//   busy        high whenever the FSM is not in IDLE
//   valid       one-cycle pulse when plaintext updates
// ---------------------------------------------------------------------------
module aes_decrypt (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [127:0] ciphertext,
  input  logic [127:0] secret,
  input  logic         we,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         valid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_KEYEXP = 2'd1,
    S_ROUND  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'd9;   // last step of KEYEXP / ROUND
  localparam logic [3:0] CNT_MAX  = 4'd10;  // anything above is illegal

  // ---------------------------------------------------------------------
  // GF(2^8) arithmetic. The S-boxes are computed, not tabulated:
  // sbox(x) = affine(x^-1) and inv_sbox(y) = (inv_affine(y))^-1.
  // ---------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 (and maps 0 to 0, as the S-box needs)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^
           {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // rcon for the step that produces rk_(idx+1) from rk_idx
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // rk_r -> rk_(r+1)
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // rk_(r+1) -> rk_r: undo the XOR chain first, then the recovered last
  // word feeds RotWord/SubWord exactly as it did going forward.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
    {w4, w5, w6, w7} = k;
    w3 = w7 ^ w6;
    w2 = w6 ^ w5;
    w1 = w5 ^ w4;
    w0 = w4 ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns unless last
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    // row r is rotated right by r columns
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c+r] = inv_sbox(a[4*((c-r+4)%4)+r]) ^ rk[127-8*(4*c+r) -: 8];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c];
        c1 = b[4*c+1];
        c2 = b[4*c+2];
        c3 = b[4*c+3];
        b[4*c]   = gmul(c0, 8'h0e) ^ gmul(c1, 8'h0b) ^ gmul(c2, 8'h0d) ^ gmul(c3, 8'h09);
        b[4*c+1] = gmul(c0, 8'h09) ^ gmul(c1, 8'h0e) ^ gmul(c2, 8'h0b) ^ gmul(c3, 8'h0d);
        b[4*c+2] = gmul(c0, 8'h0d) ^ gmul(c1, 8'h09) ^ gmul(c2, 8'h0e) ^ gmul(c3, 8'h0b);
        b[4*c+3] = gmul(c0, 8'h0b) ^ gmul(c1, 8'h0d) ^ gmul(c2, 8'h09) ^ gmul(c3, 8'h0e);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e       state_q;
  logic [3:0]   cnt_q;        // KEYEXP step index, then ROUND index (r = 9 - cnt)
  logic [127:0] data_q;       // captured ciphertext, then the round state
  logic [127:0] rk_q;         // current round key (rk0..rk10 in place)
  logic [127:0] plaintext_q;
  logic         busy_q;
  logic         valid_q;

`ifdef AES_DECRYPT_KEYCACHE_EN
  logic [127:0] sec_q;        // secret captured for this operation
  logic [127:0] cache_sec_q;
  logic [127:0] cache_rk_q;
  logic         cache_vld_q;
  logic         cache_hit;
  assign cache_hit = cache_vld_q && (secret == cache_sec_q);
`endif

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic [3:0]   rnd_idx;
  logic [127:0] rk_fwd_d;
  logic [127:0] rk_inv_d;
  logic [127:0] rnd_d;

  always_comb begin
    rnd_idx  = CNT_LAST - cnt_q;
    rk_fwd_d = key_fwd(rk_q, rcon(cnt_q));
    rk_inv_d = key_inv(rk_q, rcon(rnd_idx));
    rnd_d    = inv_round(data_q, rk_inv_d, rnd_idx == 4'd0);
  end

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      data_q      <= '0;
      rk_q        <= '0;
      plaintext_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
`ifdef AES_DECRYPT_KEYCACHE_EN
      sec_q       <= '0;
      cache_sec_q <= '0;
      cache_rk_q  <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (cnt_q > CNT_MAX) begin
        // illegal counter: abandon the operation
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= 4'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (we) begin
              cnt_q  <= 4'd0;
              busy_q <= 1'b1;
`ifdef AES_DECRYPT_KEYCACHE_EN
              sec_q  <= secret;
              if (cache_hit) begin
                data_q  <= ciphertext ^ cache_rk_q;
                rk_q    <= cache_rk_q;
                state_q <= S_ROUND;
              end else begin
                data_q  <= ciphertext;
                rk_q    <= secret;
                state_q <= S_KEYEXP;
              end
`else
              data_q  <= ciphertext;
              rk_q    <= secret;
              state_q <= S_KEYEXP;
`endif
            end
          end
          S_KEYEXP: begin
            rk_q <= rk_fwd_d;
            if (cnt_q == CNT_LAST) begin
              // rk_fwd_d is rk10: fold in the initial AddRoundKey
              data_q  <= data_q ^ rk_fwd_d;
              cnt_q   <= 4'd0;
              state_q <= S_ROUND;
`ifdef AES_DECRYPT_KEYCACHE_EN
              cache_sec_q <= sec_q;
              cache_rk_q  <= rk_fwd_d;
              cache_vld_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_ROUND: begin
            rk_q   <= rk_inv_d;
            data_q <= rnd_d;
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= 4'd0;
              state_q <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          S_DONE: begin
            plaintext_q <= data_q;
            valid_q     <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign plaintext = plaintext_q;
  assign busy      = busy_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// ---------------------------------------------------------------------------
// tb_aes_decrypt -- self-checking bench for aes_decrypt.
// A forward AES-128 model (S-box built from log/antilog tables) produces
// ciphertexts; the DUT must return the original plaintext. Latency
// expectations follow AES_DECRYPT_KEYCACHE_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_aes_decrypt;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] secret = '0;
  logic         we = 1'b0;
  logic [127:0] plaintext;
  logic         busy;
  logic         valid;

  int errors = 0;
  int checks = 0;

`ifdef AES_DECRYPT_KEYCACHE_EN
  localparam int LAT_HIT = 11;
`else
  localparam int LAT_HIT = 21;
`endif
  localparam int LAT_FULL = 21;

  always #5 clock = ~clock;

  aes_decrypt dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ciphertext (ciphertext),
    .secret     (secret),
    .we         (we),
    .plaintext  (plaintext),
    .busy       (busy),
    .valid      (valid)
  );

  // ---------------- reference model ----------------
  logic [7:0] sbox [256];
  logic [7:0] expt [256];
  int         logt [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v};
    return t[15-n -: 8];
  endfunction

  task automatic build_sbox;
    logic [7:0] e, inv;
    e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      expt[i] = e;
      logt[e] = i;
      e = e ^ xt(e);           // multiply by generator 3
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : expt[(255 - logt[x]) % 255];
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        a0 = tmp[0];
        tmp[0] = sbox[tmp[1]] ^ rc;
        tmp[1] = sbox[tmp[2]];
        tmp[2] = sbox[tmp[3]];
        tmp[3] = sbox[a0];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // One full operation: start, scramble inputs after capture, measure
  // latency and busy length, check result and single-cycle valid.
  task automatic run_op(input string tag, input logic [127:0] c, input logic [127:0] k,
                        input logic [127:0] p, input int exp_lat);
    int lat, nbusy;
    ciphertext = c;
    secret     = k;
    we         = 1'b1;
    tick;
    we         = 1'b0;
    ciphertext = rnd128();
    secret     = rnd128();
    lat   = -1;
    nbusy = busy ? 1 : 0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      tick;
      if (busy) nbusy++;
      if (valid) lat = n;
    end
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_pt"}, plaintext, p);
    chk({tag, "_busy"}, 128'(nbusy), 128'(exp_lat));
    tick;
    chk({tag, "_pulse"}, 128'(valid), 128'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] p, k, c, p2, k2;
    logic [127:0] bp [4];
    logic [127:0] bk [4];
    int nv, first_t, extra;
    int vt [4];
    logic [127:0] vp [4];

    build_sbox();

    // reset state
    tick; tick;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(valid), 128'(0));
    chk("rst_pt", plaintext, 128'h0);
    reset_n = 1'b1;
    extra = 0;
    for (int n = 0; n < 5; n++) begin
      tick;
      if (busy || valid) extra++;
    end
    chk("rst_nostart", 128'(extra), 128'(0));

    // model sanity against published vectors
    chk("model_zero", aes_enc(128'h0, 128'h0), 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    chk("model_fips", aes_enc(128'h00112233445566778899aabbccddeeff,
                              128'h000102030405060708090a0b0c0d0e0f),
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // zero case and the FIPS round trip
    run_op("zero", 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 128'h0, LAT_FULL);
    run_op("fips", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
           128'h000102030405060708090a0b0c0d0e0f,
           128'h00112233445566778899aabbccddeeff, LAT_FULL);

    // random round trips (fresh keys)
    for (int i = 0; i < 3; i++) begin
      p = rnd128(); k = rnd128();
      run_op($sformatf("rand%0d", i), aes_enc(p, k), k, p, LAT_FULL);
    end

    // we pulsed while busy must be dropped
    p = rnd128(); k = rnd128(); p2 = rnd128();
    ciphertext = aes_enc(p, k); secret = k; we = 1'b1;
    tick;
    we = 1'b0;
    nv = 0; first_t = -1;
    for (int n = 1; n <= 60; n++) begin
      if (n == 4) begin ciphertext = aes_enc(p2, k); we = 1'b1; end
      if (n == 5) we = 1'b0;
      tick;
      if (valid) begin
        nv++;
        if (first_t < 0) begin first_t = n; vp[0] = plaintext; end
      end
    end
    chk("ign_count", 128'(nv), 128'(1));
    chk("ign_lat", 128'(first_t), 128'(LAT_FULL));
    chk("ign_pt", vp[0], p);
    chk("ign_hold", plaintext, p);
    chk("ign_idle", 128'(busy), 128'(0));

    // reset in ROUND (cycle 12)
    p = rnd128(); k = rnd128();
    ciphertext = aes_enc(p, k); secret = k; we = 1'b1;
    tick;
    we = 1'b0;
    for (int n = 1; n <= 12; n++) tick;
    reset_n = 1'b0;
    #1;
    chk("rstm_busy", 128'(busy), 128'(0));
    chk("rstm_valid", 128'(valid), 128'(0));
    chk("rstm_pt", plaintext, 128'h0);
    tick;
    reset_n = 1'b1;
    extra = 0;
    for (int n = 0; n < 25; n++) begin
      tick;
      if (busy || valid) extra++;
    end
    chk("rstm_quiet", 128'(extra), 128'(0));
    run_op("rstm_redo", aes_enc(p, k), k, p, LAT_FULL);

    // reset during KEYEXP must not leave a usable cache entry
    p = rnd128(); k = rnd128();
    ciphertext = aes_enc(p, k); secret = k; we = 1'b1;
    tick;
    we = 1'b0;
    for (int n = 1; n <= 5; n++) tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    run_op("rstk_redo", aes_enc(p, k), k, p, LAT_FULL);

    // back-to-back with we held high
    for (int i = 0; i < 4; i++) begin bp[i] = rnd128(); bk[i] = rnd128(); vt[i] = -1; vp[i] = '0; end
    ciphertext = aes_enc(bp[0], bk[0]); secret = bk[0]; we = 1'b1;
    tick;
    ciphertext = aes_enc(bp[1], bk[1]); secret = bk[1];
    nv = 0;
    for (int n = 1; n <= 70; n++) begin
      tick;
      if (valid) begin
        if (nv < 4) begin vt[nv] = n; vp[nv] = plaintext; end
        nv++;
      end
      if (n == 22) begin ciphertext = aes_enc(bp[2], bk[2]); secret = bk[2]; end
      if (n == 44) begin ciphertext = aes_enc(bp[3], bk[3]); secret = bk[3]; end
    end
    we = 1'b0;
    chk("b2b_count", 128'(nv), 128'(3));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_t%0d", i), 128'(vt[i]), 128'(21 + 22*i));
      chk($sformatf("b2b_pt%0d", i), vp[i], bp[i]);
    end
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;

    // key cache: repeat key hits, flipped key misses
    k  = rnd128();
    k2 = k ^ 128'h1;
    p = rnd128(); run_op("cache_a", aes_enc(p, k), k, p, LAT_FULL);
    p = rnd128(); run_op("cache_b", aes_enc(p, k), k, p, LAT_HIT);
    p = rnd128(); run_op("cache_c", aes_enc(p, k2), k2, p, LAT_FULL);
    p = rnd128(); run_op("cache_d", aes_enc(p, k2), k2, p, LAT_HIT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
